// File: rtl/ci_issuer.sv
// Custom-instruction initiator: queues operand pairs, drives a start/clk_en/done slave,
// and returns each result over a valid/ready port. Define CI_TIMEOUT_EN to add the done watchdog.
module ci_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        ci_clk_en_o,
    output logic        ci_start_o,
    output logic [31:0] ci_dataa_o,
    output logic [31:0] ci_datab_o,
    input  logic [31:0] ci_result_i,
    input  logic        ci_done_i,
    output logic        busy_o
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [31:0]   dataa_q;
    logic [31:0]   datab_q;
    logic [31:0]   rsp_data_q;
    logic [31:0]   rsp_data_d;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          in_op;
    logic          capture;
    logic          expire;
    logic          timeout_hit;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign push    = req_valid_i && !full;
    assign in_op   = (state_q == ISSUE) || (state_q == WAIT);
    assign capture = in_op && ci_done_i;
    // A done arriving in the final watchdog cycle still counts as a real result.
    assign expire  = (state_q == WAIT) && !ci_done_i && timeout_hit;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (capture || expire) state_d = RESP;
                else                   state_d = WAIT;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_data_d = rsp_data_q;
        if (capture)     rsp_data_d = ci_result_i;
        else if (expire) rsp_data_d = '0;
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_a_i, req_b_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dataa_q    <= '0;
            datab_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rsp_data_q <= rsp_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                dataa_q  <= mem_q[rd_ptr_q][63:32];
                datab_q  <= mem_q[rd_ptr_q][31:0];
            end
        end
    end

`ifdef CI_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT) + 1 > 8) ? $clog2(TIMEOUT) + 1 : 8;

    logic [TW-1:0] wait_cnt_q;
    logic          rsp_err_q;

    // Counter reads k-1 during the k-th cycle counted from ISSUE.
    assign timeout_hit = (wait_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (pop)        wait_cnt_q <= '0;
            else if (in_op) wait_cnt_q <= wait_cnt_q + TW'(1);
            if (capture)     rsp_err_q <= 1'b0;
            else if (expire) rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign timeout_hit = (TIMEOUT < 0);
    assign rsp_err_o   = 1'b0;
`endif

    assign req_ready_o = !full;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign ci_clk_en_o = in_op;
    assign ci_start_o  = (state_q == ISSUE);
    assign ci_dataa_o  = dataa_q;
    assign ci_datab_o  = datab_q;
    assign busy_o      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_ci_issuer.sv
// Bench for ci_issuer: remainder slave model with programmable latency and a response scoreboard.
module tb_ci_issuer;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ci_clk_en;
    logic        ci_start;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic [31:0] ci_result;
    logic        ci_done;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] expData;
        int          expEdges;
    } vec_t;

    rsp_t expQ[$];
    vec_t vecs[6];
    vec_t fills[5];
    int   checks = 0;
    int   failures = 0;
    int   startCount = 0;
    int   expectedStarts = 0;
    int   slaveLat = 0;
    int   slaveCyc = 0;
    logic neverDone = 1'b0;
    logic forceDone = 1'b0;
    logic inFlight = 1'b0;

    ci_issuer #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_a_i(req_a),
        .req_b_i(req_b),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err),
        .ci_clk_en_o(ci_clk_en),
        .ci_start_o(ci_start),
        .ci_dataa_o(ci_dataa),
        .ci_datab_o(ci_datab),
        .ci_result_i(ci_result),
        .ci_done_i(ci_done),
        .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: cycle offset 0 is the start cycle; done fires at offset slaveLat.
    always @(posedge clk) begin
        if (!ci_clk_en) slaveCyc <= 0;
        else            slaveCyc <= slaveCyc + 1;
    end

    assign ci_done   = forceDone || (ci_clk_en && !neverDone && slaveCyc == slaveLat);
    assign ci_result = (ci_datab != 0) ? (ci_dataa % ci_datab) : 32'hBAD0_BAD0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pulse counting, clk_en integrity and in-order response scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            inFlight = 1'b0;
        end else begin
            if (ci_start) begin
                startCount++;
                inFlight = 1'b1;
            end
            if (inFlight && !rsp_valid) checkOutput("clk_en_inflight", 32'(ci_clk_en), 32'd1);
            if (rsp_valid) begin
                inFlight = 1'b0;
                checkOutput("clk_en_resp", 32'(ci_clk_en), 32'd0);
                if (rsp_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL rsp_unexpected: got data %0h err %0b with no request outstanding", rsp_data, rsp_err);
                    end else begin
                        rsp_t e;
                        e = expQ.pop_front();
                        checkOutput("rsp_data", rsp_data, e.data);
                        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input int lat, input logic [31:0] expData, input logic expErr,
                                 input int expEdges, input logic nd);
        int   k;
        int   firstStart;
        rsp_t e;
        @(posedge clk); #1;
        slaveLat  = lat;
        neverDone = nd;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(negedge clk);
        checkOutput({name, "_req_ready"}, 32'(req_ready), 32'd1);
        e.data = expData;
        e.err  = expErr;
        expQ.push_back(e);
        expectedStarts++;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        k          = 0;
        firstStart = -1;
        @(negedge clk);
        while (!rsp_valid && k < 60) begin
            if (ci_start && firstStart < 0) firstStart = k;
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_rsp_edges"}, 32'(k), 32'(expEdges));
        checkOutput({name, "_start_edge"}, 32'(firstStart), 32'd1);
        @(posedge clk); #1;
        neverDone = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_pending"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic sawValid;

        vecs[0] = '{"single_100_7",  32'd100,        32'd7,  3, 32'd2,  5};
        vecs[1] = '{"zero_lat_9_4",  32'd9,          32'd4,  0, 32'd1,  2};
        vecs[2] = '{"lat1_1000_33",  32'd1000,       32'd33, 1, 32'd10, 3};
        vecs[3] = '{"lat5_max_16",   32'hFFFF_FFFF,  32'd16, 5, 32'd15, 7};
        vecs[4] = '{"lat2_div_one",  32'd12345,      32'd1,  2, 32'd0,  4};
        vecs[5] = '{"lat0_small",    32'd5,          32'd9,  0, 32'd5,  2};

        fills[0] = '{"fill0", 32'd100, 32'd7, 1, 32'd2, 0};
        fills[1] = '{"fill1", 32'd50,  32'd6, 1, 32'd2, 0};
        fills[2] = '{"fill2", 32'd33,  32'd5, 1, 32'd3, 0};
        fills[3] = '{"fill3", 32'd17,  32'd3, 1, 32'd2, 0};
        fills[4] = '{"fill4", 32'd8,   32'd8, 1, 32'd0, 0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_data",  rsp_data,       32'd0);
        checkOutput("reset_rsp_err",   32'(rsp_err),   32'd0);
        checkOutput("reset_ci_start",  32'(ci_start),  32'd0);
        checkOutput("reset_ci_clk_en", 32'(ci_clk_en), 32'd0);
        checkOutput("reset_ci_dataa",  ci_dataa,       32'd0);
        checkOutput("reset_ci_datab",  ci_datab,       32'd0);
        checkOutput("reset_busy",      32'(busy),      32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] single-request vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].lat,
                          vecs[i].expData, 1'b0, vecs[i].expEdges, 1'b0);
        end
        checkOutput("vec_operand_a_held", ci_dataa, 32'd5);
        checkOutput("vec_operand_b_held", ci_datab, 32'd9);
        waitDrain("vectors");

        $display("[TB] fill and backpressure");
        rsp_ready = 1'b0;
        slaveLat  = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_a     = fills[i].a;
            req_b     = fills[i].b;
            req_valid = 1'b1;
            @(negedge clk);
            checkOutput({fills[i].name, "_req_ready"}, 32'(req_ready), 32'd1);
            begin
                rsp_t e;
                e.data = fills[i].expData;
                e.err  = 1'b0;
                expQ.push_back(e);
            end
            expectedStarts++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("fill_full_req_ready", 32'(req_ready), 32'd0);
        checkOutput("fill_busy",           32'(busy),      32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_data",  rsp_data,       32'd2);
            checkOutput("bp_rsp_err",   32'(rsp_err),   32'd0);
            checkOutput("bp_ci_clk_en", 32'(ci_clk_en), 32'd0);
            checkOutput("bp_ci_start",  32'(ci_start),  32'd0);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b_ci_start", 32'(ci_start), 32'd1);
        checkOutput("b2b_ci_dataa", ci_dataa,      32'd50);
        checkOutput("b2b_ci_datab", ci_datab,      32'd6);
        waitDrain("fill");

`ifdef CI_TIMEOUT_EN
        $display("[TB] watchdog");
        applyStimulus("timeout",       32'd77,  32'd5, 0, 32'd0, 1'b1, 9, 1'b1);
        applyStimulus("after_timeout", 32'd77,  32'd5, 2, 32'd2, 1'b0, 4, 1'b0);
        applyStimulus("done_8th",      32'd200, 32'd9, 7, 32'd2, 1'b0, 9, 1'b0);
        waitDrain("watchdog");
`endif

        $display("[TB] reset mid-operation");
        slaveLat = 20;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req_a     = 32'(40 + i);
            req_b     = 32'd3;
            req_valid = 1'b1;
            @(negedge clk);
            checkOutput("rst_seq_req_ready", 32'(req_ready), 32'd1);
        end
        expectedStarts++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_busy",      32'(busy),      32'd1);
        checkOutput("pre_reset_ci_clk_en", 32'(ci_clk_en), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_rsp_data",  rsp_data,       32'd0);
        checkOutput("midrst_ci_start",  32'(ci_start),  32'd0);
        checkOutput("midrst_ci_clk_en", 32'(ci_clk_en), 32'd0);
        checkOutput("midrst_ci_dataa",  ci_dataa,       32'd0);
        checkOutput("midrst_ci_datab",  ci_datab,       32'd0);
        checkOutput("midrst_busy",      32'(busy),      32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        forceDone = 1'b1;
        sawValid  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || ci_start) sawValid = 1'b1;
        end
        forceDone = 1'b0;
        checkOutput("late_done_no_activity", 32'(sawValid), 32'd0);
        checkOutput("post_reset_busy",       32'(busy),     32'd0);

        applyStimulus("post_reset_op", 32'd31, 32'd4, 1, 32'd3, 1'b0, 3, 1'b0);
        waitDrain("final");
        checkOutput("start_pulse_count", 32'(startCount), 32'(expectedStarts));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
